clk_div_prog: RTL and testbench
===============================

Name: clk_div_prog

Overview:
- Parametrised, multi-channel programmable clock divider and tick generator.
- Successor to the fixed power-of-two ripple divider. Provides exact integer divide ratios, per-channel enable, and glitch-free runtime divisor reload through a valid/ready port.
- Sits beside the ALU/display logic on the 50 MHz board clock. It feeds 10 kHz scan and 500 Hz refresh domains as clock-enable ticks plus registered square waves.

Parameters:
- NUM_CH, 2, number of independent divider channels (1..8).
- CNT_W, 17, counter and divisor width in bits.
- DIV_DEFAULT, 5000, reset divisor for every channel (50 MHz -> 10 kHz). Must satisfy 2 <= DIV_DEFAULT <= 2^CNT_W-1.

Ports:
- clk_50MHz  in  1  board clock; all state on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  NUM_CH  per-channel run enable.
- restart  in  1  synchronous restart: all channel counters go to 0.
- div_valid  in  1  divisor load request.
- div_ch  in  $clog2(NUM_CH) (min 1)  target channel of the load.
- div_value  in  CNT_W  requested divisor.
- div_ready  out  1  load can be accepted for div_ch.
- tick  out  NUM_CH  one-cycle pulse per divided period.
- clk_out  out  NUM_CH  registered divided square wave.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - cnt=0, active_div=DIV_DEFAULT, shadow=DIV_DEFAULT, pending=0 for every channel.
  - tick=0, clk_out=0, div_ready=1.
- Running channel (en[i]=1):
  - cnt counts 0..active_div-1 and wraps to 0, so the period is exactly active_div cycles.
  - wrap = (cnt==active_div-1).
- tick[i]:
  - Registered: tick_q <= en[i] & wrap.
  - High for exactly one cycle; consecutive pulses are exactly active_div cycles apart.
- clk_out[i]:
  - Registered: clk_out_q <= en[i] & (cnt_next < (active_div>>1)).
  - Gives a high time of D>>1 cycles and a low time of D-(D>>1) cycles. D=2 gives 1/1; D=5 gives 2/3.
- Disabled channel (en[i]=0):
  - cnt is held at 0; tick and clk_out go to 0 on the next edge.
  - When en[i] rises again, counting restarts from 0 and the first tick comes active_div cycles later.
- restart=1:
  - Every cnt goes to 0 next edge; the tick for that cycle is suppressed.
  - active_div, shadow and pending are unchanged.
  - restart takes priority over wrap.
- div_ready = ~pending[div_ch] (combinational).
- Load handshake:
  - A load is accepted when div_valid & div_ready: shadow[div_ch] <= clamp(div_value) and pending[div_ch] <= 1.
  - clamp: values 0 and 1 become 2.
  - div_valid with div_ready=0 is ignored; the requester must hold div_valid until it sees ready.
- Apply point (glitch-free):
  - For a pending channel, on an edge where wrap=1 or en[i]=0 or restart=1: active_div <= shadow and pending <= 0.
  - The current period is never truncated.
- Accept and wrap in the same cycle: the new value goes to shadow only. It is applied at the next wrap, not this one.
- div_ch >= NUM_CH: div_ready=0 and the load is never accepted.
- Reset mid-operation (asynchronous) discards any pending load and returns to the reset values above.
- No divisor arithmetic ever overflows CNT_W: cnt_next is compared before increment, and the clamp guarantees D >= 2.

Decomposition:
- Package clk_div_pkg holds:
  - CNT_W_DEF=17 and DIV_MIN=2.
  - Named divisors: DIV_10K=5000, DIV_500=100000, DIV_1K=50000.
  - Function clamp_div.
- Sub-module clk_div_channel (one instance per channel):
  - Owns cnt, active_div, shadow, pending, tick_q and clk_out_q.
  - Inputs: load strobe, load value, en, restart.
- Top level clk_div_prog does the div_ch decode, drives div_ready, and instantiates the NUM_CH channels in a generate loop.

Test Plan:
1. Reset release with DIV_DEFAULT=5, en=2'b01 -> tick[0] pulses every 5 cycles, clk_out[0] high 2 / low 3; tick[1] and clk_out[1] stay 0.
2. Load div_value=8 on ch0 mid-period at cnt=2 -> div_ready for ch0 drops the next cycle; the current 5-cycle period completes; following periods are 8 cycles (4 high / 4 low); ready returns 1 after the apply.
3. Load div_value=1 on ch1 with en[1]=0 -> applied the next edge as 2; after en[1]=1, tick[1] pulses every 2 cycles and clk_out[1] toggles each cycle.
4. Second load to ch0 while pending -> div_ready=0 and the value is ignored; load to ch1 in the same window -> accepted.
5. Assert restart at cnt=3 of ch0 -> no tick that cycle; the next tick comes exactly DIV cycles after restart.
6. Drive rst_n low mid-period with a load pending -> all outputs 0 immediately (asynchronous); after release the period is DIV_DEFAULT and the pending value is lost.

Source files
------------

// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_pkg
//  Description : Shared constants and helpers for the programmable clock
//                divider: default widths, the minimum legal divisor, named
//                board-clock divisors and the divisor clamp.
//  Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    localparam int CNT_W_DEF = 17;
    localparam int DIV_MIN   = 2;

    // Named divisors from the 50 MHz board clock.
    localparam int DIV_10K   = 5000;
    localparam int DIV_500   = 100000;
    localparam int DIV_1K    = 50000;

    // A divisor of 0 or 1 has no meaningful period; force it to the minimum.
    function automatic logic [31:0] clamp_div(input logic [31:0] value);
        return (value < 32'(DIV_MIN)) ? 32'(DIV_MIN) : value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_prog_if.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_prog_if
//  Description : Divisor-load handshake between a requester (master) and the
//                clock divider (slave). Ready is per target channel.
//  Revision    : 1.0 - initial release
// ============================================================================
interface clk_div_prog_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = clk_div_pkg::CNT_W_DEF
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              div_valid;
    logic [CH_W-1:0]   div_ch;
    logic [CNT_W-1:0]  div_value;
    logic              div_ready;

    modport master (
        output div_valid,
        output div_ch,
        output div_value,
        input  div_ready
    );

    modport slave (
        input  div_valid,
        input  div_ch,
        input  div_value,
        output div_ready
    );

endinterface
`default_nettype wire

// File: rtl/clk_div_channel.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_channel
//  Description : One divider channel. Counts 0..active_div-1, emits a one-cycle
//                tick per period and a registered square wave. A loaded divisor
//                waits in a shadow register and is applied only at a period
//                boundary, while disabled, or on restart, so a running period
//                is never truncated.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DIV_DEFAULT = DIV_10K
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_restart,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_value,
    output logic             o_pending,
    output logic             o_tick,
    output logic             o_clk_out
);

    localparam logic [CNT_W-1:0] c_div_default = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_active_div;
    logic [CNT_W-1:0] r_shadow;
    logic             r_pending;
    logic             r_tick;
    logic             r_clk_out;

    logic             w_wrap;
    logic             w_apply;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_half;
    logic [CNT_W-1:0] w_load_div;

    // Active divisor is always >= 2, so active_div-1 never underflows.
    assign w_wrap     = (r_cnt == r_active_div - c_one);
    assign w_half     = r_active_div >> 1;
    assign w_load_div = CNT_W'(clamp_div(32'(i_load_value)));
    assign w_apply    = r_pending & (w_wrap | ~i_en | i_restart);

    // Next count: restart and disable force zero ahead of the natural wrap.
    always_comb begin
        w_cnt_next = r_cnt + c_one;
        if (~i_en || i_restart || w_wrap) begin
            w_cnt_next = '0;
        end
    end

    // Counter plus registered tick and square-wave outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_tick    <= 1'b0;
            r_clk_out <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_tick    <= i_en & w_wrap & ~i_restart;
            r_clk_out <= i_en & (w_cnt_next < w_half);
        end
    end

    // Shadow/active divisor pair; a load is only offered while nothing is
    // pending, so apply and load never collide on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active_div <= c_div_default;
            r_shadow     <= c_div_default;
            r_pending    <= 1'b0;
        end else begin
            if (w_apply) begin
                r_active_div <= r_shadow;
                r_pending    <= 1'b0;
            end
            if (i_load) begin
                r_shadow  <= w_load_div;
                r_pending <= 1'b1;
            end
        end
    end

    assign o_pending = r_pending;
    assign o_tick    = r_tick;
    assign o_clk_out = r_clk_out;

endmodule
`default_nettype wire

// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_prog
//  Description : Multi-channel programmable clock divider / tick generator.
//                Decodes the divisor-load target channel, drives the per-
//                channel ready, and instantiates one divider per channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DIV_DEFAULT = DIV_10K
) (
    input  logic              clk_50MHz,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              restart,
    clk_div_prog_if.slave     div_if,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] w_pending;
    logic [NUM_CH-1:0] w_load;
    logic              w_ready;

    // Ready mirrors the target channel's free shadow; out-of-range targets
    // match no channel and therefore stay not-ready.
    always_comb begin
        w_ready = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (div_if.div_ch == CH_W'(i)) begin
                w_ready = ~w_pending[i];
            end
        end
    end

    assign div_if.div_ready = w_ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_load[g] = div_if.div_valid & w_ready & (div_if.div_ch == CH_W'(g));

        clk_div_channel #(
            .CNT_W       (CNT_W),
            .DIV_DEFAULT (DIV_DEFAULT)
        ) u_channel (
            .clk          (clk_50MHz),
            .rst_n        (rst_n),
            .i_en         (en[g]),
            .i_restart    (restart),
            .i_load       (w_load[g]),
            .i_load_value (div_if.div_value),
            .o_pending    (w_pending[g]),
            .o_tick       (tick[g]),
            .o_clk_out    (clk_out[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_prog.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_div_prog
//  Description : Self-checking bench for clk_div_prog. A timestamp-based
//                reference model predicts tick / clk_out / ready for each edge
//                and queues them; a monitor compares on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_prog;

    localparam int NUM_CH  = 2;
    localparam int CNT_W   = 17;
    localparam int DIV_DEF = 5;

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b0;
    logic [NUM_CH-1:0] en      = '0;
    logic              restart = 1'b0;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] clk_out;

    clk_div_prog_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) div_if ();

    clk_div_prog #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DIV_DEFAULT (DIV_DEF)
    ) dut (
        .clk_50MHz (clk),
        .rst_n     (rst_n),
        .en        (en),
        .restart   (restart),
        .div_if    (div_if),
        .tick      (tick),
        .clk_out   (clk_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_CH-1:0] tick;
        logic [NUM_CH-1:0] clk_out;
        logic              ready;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: each channel remembers the edge number at which its
    // current period began and the divisor in force.
    longint t_edge = 0;
    longint start_t [NUM_CH];
    int     div_m   [NUM_CH];
    int     shadow_m[NUM_CH];
    bit     pend_m  [NUM_CH];

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp_v, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            start_t[i]  = t_edge;
            div_m[i]    = DIV_DEF;
            shadow_m[i] = DIV_DEF;
            pend_m[i]   = 1'b0;
        end
    endtask

    // Drive inputs for the coming rising edge and queue the predicted outputs.
    task automatic apply_inputs(input logic [NUM_CH-1:0] en_v, input logic rs,
                                input logic vld, input int ch, input int val);
        exp_t   e;
        bit     pend_pre[NUM_CH];
        longint elapsed;
        bit     boundary;
        en               = en_v;
        restart          = rs;
        div_if.div_valid = vld;
        div_if.div_ch    = 1'(ch);
        div_if.div_value = CNT_W'(val);
        t_edge++;
        pend_pre = pend_m;
        for (int i = 0; i < NUM_CH; i++) begin
            elapsed    = t_edge - start_t[i];
            boundary   = (elapsed == longint'(div_m[i]));
            e.tick[i]  = en_v[i] && boundary && !rs;
            if (!en_v[i] || rs || boundary) start_t[i] = t_edge;
            e.clk_out[i] = en_v[i] && ((t_edge - start_t[i]) < longint'(div_m[i] / 2));
            if (pend_m[i] && (boundary || !en_v[i] || rs)) begin
                div_m[i]  = shadow_m[i];
                pend_m[i] = 1'b0;
            end
        end
        if (vld && ch < NUM_CH && !pend_pre[ch]) begin
            shadow_m[ch] = (val < 2) ? 2 : val;
            pend_m[ch]   = 1'b1;
        end
        e.ready = (ch < NUM_CH) && !pend_m[ch];
        sb_q.push_back(e);
    endtask

    task automatic cyc(input logic [NUM_CH-1:0] en_v, input logic rs,
                       input logic vld, input int ch, input int val);
        @(negedge clk);
        #1;
        apply_inputs(en_v, rs, vld, ch, val);
    endtask

    // Asynchronous reset mid-cycle, immediate output check, then release and
    // drive the first post-reset cycle in the same slot.
    task automatic do_reset(input logic [NUM_CH-1:0] en_after);
        @(negedge clk);
        #1;
        rst_n            = 1'b0;
        div_if.div_valid = 1'b0;
        div_if.div_ch    = '0;
        #1;
        chk("rst_tick", int'(tick), 0);
        chk("rst_clk_out", int'(clk_out), 0);
        chk("rst_ready", int'(div_if.div_ready), 1);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        apply_inputs(en_after, 1'b0, 1'b0, 0, 0);
    endtask

    // Monitor: compare the DUT against each queued prediction.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("tick", int'(tick), int'(e.tick));
                chk("clk_out", int'(clk_out), int'(e.clk_out));
                chk("div_ready", int'(div_if.div_ready), int'(e.ready));
            end
        end
    end

    initial begin : stimulus
        div_if.div_valid = 1'b0;
        div_if.div_ch    = '0;
        div_if.div_value = '0;
        model_reset();

        // Default divisor on channel 0 only.
        do_reset(2'b01);
        repeat (11) cyc(2'b01, 1'b0, 1'b0, 0, 0);

        // Mid-period load of 8 on channel 0.
        cyc(2'b01, 1'b0, 1'b1, 0, 8);
        repeat (25) cyc(2'b01, 1'b0, 1'b0, 0, 0);

        // Load 1 (clamped to 2) on disabled channel 1, then enable it.
        cyc(2'b01, 1'b0, 1'b1, 1, 1);
        repeat (3) cyc(2'b01, 1'b0, 1'b0, 1, 0);
        repeat (10) cyc(2'b11, 1'b0, 1'b0, 1, 0);

        // Second load to a pending channel is ignored; other channel accepts.
        cyc(2'b11, 1'b0, 1'b1, 0, 9);
        cyc(2'b11, 1'b0, 1'b1, 0, 3);
        cyc(2'b11, 1'b0, 1'b1, 1, 3);
        repeat (20) cyc(2'b11, 1'b0, 1'b0, 0, 0);

        // Restart mid-period.
        repeat (3) cyc(2'b11, 1'b0, 1'b0, 0, 0);
        cyc(2'b11, 1'b1, 1'b0, 0, 0);
        repeat (12) cyc(2'b11, 1'b0, 1'b0, 0, 0);

        // Reset with a load pending: the load must be lost.
        cyc(2'b11, 1'b0, 1'b1, 0, 7);
        cyc(2'b11, 1'b0, 1'b0, 0, 0);
        do_reset(2'b11);
        repeat (12) cyc(2'b11, 1'b0, 1'b0, 0, 0);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            logic [NUM_CH-1:0] en_r;
            en_r[0] = ($urandom_range(0, 7) != 0);
            en_r[1] = ($urandom_range(0, 7) != 0);
            if (n % 750 == 749) begin
                do_reset(en_r);
            end else begin
                cyc(en_r, ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0),
                    int'($urandom_range(0, 1)), int'($urandom_range(0, 13)));
            end
        end

        for (int k = 0; k < 4 && sb_q.size() > 0; k++) begin
            @(negedge clk);
            #1;
        end
        chk("scoreboard_drain", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
